// File: rtl/ahb_cmd_master_if.sv
// ahb_cmd_master_if: command/response handshake plus AHB-Lite master bus.
// The master modport is the block's view; slave is the command source and bus slave.
interface ahb_cmd_master_if;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   logic        rsp_vld;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic [1:0]  hresp;

   modport master (
      input  cmd_vld, cmd_write, cmd_addr, cmd_size, cmd_wdata, hrdata, hready, hresp,
      output cmd_rdy, rsp_vld, rsp_rdata, rsp_err, haddr, htrans, hwrite, hsize, hprot, hwdata
   );

   modport slave (
      output cmd_vld, cmd_write, cmd_addr, cmd_size, cmd_wdata, hrdata, hready, hresp,
      input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err, haddr, htrans, hwrite, hsize, hprot, hwdata
   );
endinterface

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: issues one AHB-Lite NONSEQ transfer per accepted command and
// rejects misaligned or oversized commands locally without touching the bus.
module ahb_cmd_master #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input logic              hclk,
   input logic              hrst_b,
   ahb_cmd_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

   state_e      state_q, state_d;
   logic [31:0] haddr_q, haddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [2:0]  hsize_q, hsize_d;
   logic        hwrite_q, hwrite_d;
   logic        err_q, err_d;
   logic        bad_cmd;
   logic        bus_err;

   assign bad_cmd = (bus.cmd_size > 3'd2) ||
                    (bus.cmd_size == 3'd1 && bus.cmd_addr[0]) ||
                    (bus.cmd_size == 3'd2 && bus.cmd_addr[1:0] != 2'b00);
   assign bus_err = bus.hresp != 2'b00;

   always_comb begin
      state_d  = state_q;
      haddr_d  = haddr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      hsize_d  = hsize_q;
      hwrite_d = hwrite_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: if (bus.cmd_vld) begin
            haddr_d  = bus.cmd_addr;
            wdata_d  = bus.cmd_wdata;
            hsize_d  = bus.cmd_size;
            hwrite_d = bus.cmd_write;
            state_d  = bad_cmd ? RESP : ADDR;
            if (bad_cmd) begin
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         ADDR: state_d = bus.hready ? DATA : ADDR;
         // Response fields only change on the edge into RESP so they hold until the next one.
         DATA: if (bus.hready) begin
            state_d = RESP;
            err_d   = bus_err;
            rdata_d = (!hwrite_q && !bus_err) ? bus.hrdata : '0;
         end
         RESP: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         state_q  <= IDLE;
         haddr_q  <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         hsize_q  <= '0;
         hwrite_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         hsize_q  <= hsize_d;
         hwrite_q <= hwrite_d;
         err_q    <= err_d;
      end
   end

   assign bus.cmd_rdy   = state_q == IDLE;
   assign bus.rsp_vld   = state_q == RESP;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.htrans    = (state_q == ADDR) ? 2'b10 : 2'b00;
   assign bus.haddr     = haddr_q;
   assign bus.hwrite    = hwrite_q;
   assign bus.hsize     = hsize_q;
   assign bus.hprot     = HPROT_VAL;
   assign bus.hwdata    = (state_q == DATA) ? wdata_q : '0;
endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: directed and random commands against a transaction-level
// model of latency, bus activity and response values.
module tb_ahb_cmd_master;
   logic clk;
   logic hrst_b;
   int   checks = 0;
   int   errors = 0;

   ahb_cmd_master_if bus ();

   ahb_cmd_master #(.HPROT_VAL(4'b0011)) dut (
      .hclk  (clk),
      .hrst_b(hrst_b),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts at posedge+1 with the block idle; slave timing follows aw/dw wait counts.
   task automatic run(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input int aw, input int dw,
                      input logic [1:0] rsp, input logic [31:0] rd, input bit twoerr);
      bit          bad;
      int          lat, exp_lat;
      logic        exp_err, got_err;
      logic [31:0] exp_rd, got_rd, exp_hwd;
      logic [1:0]  exp_tr;
      bad     = (sz > 3'd2) || ((a % (32'd1 << sz)) != 32'd0);
      exp_lat = bad ? 1 : aw + dw + 3;
      exp_err = bad || (rsp != 2'b00);
      exp_rd  = (!bad && !w && rsp == 2'b00) ? rd : 32'd0;
      got_err = 1'b0;
      got_rd  = 32'd0;
      bus.cmd_vld   = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_size  = sz;
      bus.cmd_wdata = wd;
      bus.hready    = 1'b1;
      bus.hresp     = 2'b00;
      @(negedge clk);
      chk("cmd_rdy_idle", {31'd0, bus.cmd_rdy}, 32'd1);
      @(posedge clk);
      #1;
      bus.cmd_vld   = 1'b0;
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      bus.cmd_write = ~w;
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         bus.hrdata = $urandom;
         bus.hready = 1'b1;
         bus.hresp  = 2'b00;
         if (!bad) begin
            if (n <= aw) bus.hready = 1'b0;
            else if (n > aw + 1 && n <= aw + 1 + dw) begin
               bus.hready = 1'b0;
               bus.hresp  = (twoerr && n == aw + 1 + dw) ? 2'b01 : 2'b00;
            end else if (n == aw + 2 + dw) begin
               bus.hresp  = rsp;
               bus.hrdata = rd;
            end
         end
         @(negedge clk);
         exp_tr  = (!bad && n <= aw + 1) ? 2'b10 : 2'b00;
         exp_hwd = (!bad && n >= aw + 2 && n <= aw + 2 + dw) ? wd : 32'd0;
         chk("hprot", {28'd0, bus.hprot}, 32'h3);
         chk("htrans", {30'd0, bus.htrans}, {30'd0, exp_tr});
         chk("hwdata", bus.hwdata, exp_hwd);
         chk("cmd_rdy_busy", {31'd0, bus.cmd_rdy}, 32'd0);
         if (exp_tr == 2'b10) begin
            chk("haddr", bus.haddr, a);
            chk("hwrite", {31'd0, bus.hwrite}, {31'd0, w});
            chk("hsize", {29'd0, bus.hsize}, {29'd0, sz});
         end
         if (bus.rsp_vld) begin
            lat     = n;
            got_err = bus.rsp_err;
            got_rd  = bus.rsp_rdata;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("latency", lat, exp_lat);
      chk("rsp_err", {31'd0, got_err}, {31'd0, exp_err});
      chk("rsp_rdata", got_rd, exp_rd);
      chk("haddr_hold", bus.haddr, a);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rsp_vld_pulse", {31'd0, bus.rsp_vld}, 32'd0);
      chk("cmd_rdy_after", {31'd0, bus.cmd_rdy}, 32'd1);
      chk("rsp_rdata_hold", bus.rsp_rdata, exp_rd);
      chk("rsp_err_hold", {31'd0, bus.rsp_err}, {31'd0, exp_err});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_htrans", {30'd0, bus.htrans}, 32'd0);
      chk("rst_haddr", bus.haddr, 32'd0);
      chk("rst_hwrite", {31'd0, bus.hwrite}, 32'd0);
      chk("rst_hsize", {29'd0, bus.hsize}, 32'd0);
      chk("rst_hwdata", bus.hwdata, 32'd0);
      chk("rst_rsp_vld", {31'd0, bus.rsp_vld}, 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      chk("rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
      chk("rst_hprot", {28'd0, bus.hprot}, 32'h3);
   endtask

   initial begin
      logic [2:0]  sz;
      logic [31:0] a;
      logic [1:0]  rsp;
      int          aw, dw;
      hrst_b        = 1'b0;
      bus.cmd_vld   = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_size  = '0;
      bus.cmd_wdata = '0;
      bus.hrdata    = '0;
      bus.hready    = 1'b1;
      bus.hresp     = 2'b00;
      #2;
      chk_reset_vals();
      @(posedge clk);
      #1;
      hrst_b = 1'b1;
      run(1'b0, 32'h4000_0010, 3'd2, 32'h0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0);
      run(1'b1, 32'h2000_0002, 3'd1, 32'h0000_A5A5, 0, 0, 2'b00, 32'h1111_2222, 1'b0);
      run(1'b0, 32'h4000_0020, 3'd2, 32'h0, 2, 3, 2'b00, 32'h0BAD_F00D, 1'b0);
      run(1'b0, 32'h4000_0030, 3'd2, 32'h0, 0, 1, 2'b01, 32'h5555_AAAA, 1'b1);
      run(1'b0, 32'h0000_1002, 3'd2, 32'h0, 0, 0, 2'b00, 32'h0, 1'b0);
      run(1'b0, 32'h0000_0004, 3'd3, 32'h0, 0, 0, 2'b00, 32'h0, 1'b0);
      run(1'b0, 32'h0000_0003, 3'd0, 32'h0, 0, 0, 2'b00, 32'h0000_00C3, 1'b0);
      run(1'b0, 32'h0000_1234, 3'd1, 32'h0, 1, 0, 2'b00, 32'h1234_5678, 1'b0);
      // Reset asserted mid-DATA while the slave is stalling.
      bus.cmd_vld   = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h3000_0008;
      bus.cmd_size  = 3'd2;
      bus.cmd_wdata = 32'hCAFE_0001;
      @(posedge clk);
      #1;
      bus.cmd_vld = 1'b0;
      @(posedge clk);
      #1;
      bus.hready = 1'b0;
      @(negedge clk);
      chk("pre_rst_hwdata", bus.hwdata, 32'hCAFE_0001);
      #2;
      hrst_b = 1'b0;
      #1;
      chk_reset_vals();
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_rsp", {31'd0, bus.rsp_vld}, 32'd0);
         chk("rst_cmd_rdy_hold", {31'd0, bus.cmd_rdy}, 32'd1);
      end
      @(posedge clk);
      #1;
      hrst_b = 1'b1;
      run(1'b0, 32'h5000_0000, 3'd2, 32'h0, 0, 0, 2'b00, 32'h7777_8888, 1'b0);
      for (int t = 0; t < 40; t++) begin
         sz = ($urandom_range(0, 5) == 5) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         a  = $urandom;
         if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a - (a % (32'd1 << sz));
         aw  = $urandom_range(0, 3);
         dw  = $urandom_range(0, 3);
         rsp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run(1'($urandom_range(0, 1)), a, sz, $urandom, aw, dw, rsp, $urandom,
             rsp == 2'b01 && dw >= 1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
